// File: rtl/jtag_user_responder.sv
// Target-side ECP5 JTAGG ER1 user-register responder: oversampled scan chain with TX/RX handshakes.
// Optional saturating RX overwrite counter enabled by defining JTAG_RESPONDER_OVERFLOW_EN.
module jtag_user_responder #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             jtck,
   input  logic             jtdi,
   input  logic             jshift,
   input  logic             jupdate,
   input  logic             jce1,
   input  logic             jrstn,
   output logic             jtdo1,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready
`ifdef JTAG_RESPONDER_OVERFLOW_EN
   ,
   output logic [7:0]       overflow_count
`endif
);

   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   logic [5:0]       raw_s;
   logic [5:0]       sync_r [STAGES];
   logic             jtck_s, jtdi_s, jshift_s, jupdate_s, jce1_s, jrstn_s;
   logic             jtck_prev_r, jupdate_prev_r;
   logic             jtck_rise_s, jupdate_rise_s;
   logic             capture_s, shift_s, update_s, tx_load_s;
   state_t           state_r;
   logic [WIDTH:0]   shreg_r;
   logic [WIDTH-1:0] hold_data_r;
   logic             hold_full_r;
   logic             jtdo1_r;
   logic [WIDTH-1:0] rx_data_r;
   logic             rx_valid_r;

   assign raw_s = {jtck, jtdi, jshift, jupdate, jce1, jrstn};
   assign {jtck_s, jtdi_s, jshift_s, jupdate_s, jce1_s, jrstn_s} = sync_r[STAGES-1];

   assign jtck_rise_s    = jtck_s & ~jtck_prev_r;
   assign jupdate_rise_s = jupdate_s & ~jupdate_prev_r;

   // Capture/shift/update qualified by state; a TAP reset blocks them all.
   assign capture_s = jrstn_s & (state_r == IDLE) & jtck_rise_s & jce1_s & ~jshift_s;
   assign shift_s   = jrstn_s & (state_r == SHIFT) & jtck_rise_s & jce1_s & jshift_s;
   assign update_s  = jrstn_s & (state_r == SHIFT) & jupdate_rise_s;
   assign tx_load_s = tx_valid & ~hold_full_r;

   assign jtdo1    = jtdo1_r;
   assign tx_ready = ~hold_full_r;
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;

   // Synchronizer chain and edge-detect history for all JTAGG strobes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_r[i] <= 6'b000000;
         end
         jtck_prev_r    <= 1'b0;
         jupdate_prev_r <= 1'b0;
      end else begin
         sync_r[0] <= raw_s;
         for (int i = 1; i < STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         jtck_prev_r    <= jtck_s;
         jupdate_prev_r <= jupdate_s;
      end
   end

   // Scan FSM, TX holding register and RX output register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         shreg_r     <= {(WIDTH+1){1'b0}};
         hold_data_r <= {WIDTH{1'b0}};
         hold_full_r <= 1'b0;
         jtdo1_r     <= 1'b0;
         rx_data_r   <= {WIDTH{1'b0}};
         rx_valid_r  <= 1'b0;
      end else begin
         jtdo1_r <= shreg_r[0];

         // A load can only happen when empty, so it wins over the capture's clear.
         if (tx_load_s) begin
            hold_data_r <= tx_data;
            hold_full_r <= 1'b1;
         end else if (capture_s) begin
            hold_full_r <= 1'b0;
         end else begin
            hold_full_r <= hold_full_r;
         end

         if (update_s && shreg_r[0]) begin
            rx_data_r  <= shreg_r[WIDTH:1];
            rx_valid_r <= 1'b1;
         end else if (rx_valid_r && rx_ready) begin
            rx_valid_r <= 1'b0;
         end else begin
            rx_valid_r <= rx_valid_r;
         end

         if (!jrstn_s) begin
            state_r <= IDLE;
            shreg_r <= {(WIDTH+1){1'b0}};
         end else begin
            case (state_r)
               IDLE: begin
                  if (capture_s) begin
                     shreg_r <= hold_full_r ? {hold_data_r, 1'b1} : {(WIDTH+1){1'b0}};
                     state_r <= SHIFT;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               SHIFT: begin
                  if (update_s) begin
                     state_r <= DONE;
                  end else if (shift_s) begin
                     shreg_r <= {jtdi_s, shreg_r[WIDTH:1]};
                  end else begin
                     state_r <= SHIFT;
                  end
               end
               DONE: begin
                  state_r <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef JTAG_RESPONDER_OVERFLOW_EN
   logic [7:0] overflow_count_r;
   logic       overwrite_s;
   logic       ovf_clear_s;

   // An overwrite only counts if the consumer is not taking the old word this cycle.
   assign overwrite_s    = update_s & shreg_r[0] & rx_valid_r & ~rx_ready;
   assign ovf_clear_s    = rx_ready & ~rx_valid_r & ~jce1_s;
   assign overflow_count = overflow_count_r;

   // Saturating overwrite counter with consumer-driven clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_count_r <= 8'd0;
      end else if (overwrite_s && (overflow_count_r != 8'd255)) begin
         overflow_count_r <= overflow_count_r + 8'd1;
      end else if (ovf_clear_s) begin
         overflow_count_r <= 8'd0;
      end else begin
         overflow_count_r <= overflow_count_r;
      end
   end
`endif

endmodule

// File: tb/tb_jtag_user_responder.sv
// Self-checking bench for jtag_user_responder: vector table, hand-written corner sequences, random vs. model.
module tb_jtag_user_responder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       jtck = 1'b0, jtdi = 1'b0, jshift = 1'b0, jupdate = 1'b0, jce1 = 1'b0, jrstn = 1'b1;
   logic       jtdo1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
`ifdef JTAG_RESPONDER_OVERFLOW_EN
   logic [7:0] overflow_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   jtag_user_responder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .jtck(jtck), .jtdi(jtdi), .jshift(jshift),
      .jupdate(jupdate), .jce1(jce1), .jrstn(jrstn), .jtdo1(jtdo1),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef JTAG_RESPONDER_OVERFLOW_EN
      , .overflow_count(overflow_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       load;
      logic [7:0] load_data;
      logic [8:0] tdi;
      logic [8:0] exp_tdo;
      logic       exp_rx_valid;
      logic [7:0] exp_rx_data;
      logic [7:0] exp_ovf;
      logic       consume;
   } vec_t;

   vec_t vecs[6];

   // Behavioural model of the channel as seen from both ends.
   logic       m_hold_full;
   logic [7:0] m_hold_data;
   logic       m_rx_valid;
   logic [7:0] m_rx_data;
   int         m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic tck_pulse();
      jtck = 1'b1;
      wait_clk(8);
      jtck = 1'b0;
      wait_clk(8);
   endtask

   task automatic capture();
      jce1 = 1'b1;
      jshift = 1'b0;
      wait_clk(2);
      tck_pulse();
      jshift = 1'b1;
   endtask

   task automatic shift_bit(input logic b);
      jtdi = b;
      wait_clk(1);
      tck_pulse();
   endtask

   task automatic update();
      jce1 = 1'b0;
      jshift = 1'b0;
      wait_clk(2);
      jupdate = 1'b1;
      wait_clk(4);
      jupdate = 1'b0;
      wait_clk(4);
   endtask

   task automatic scan(input logic [8:0] tdi, output logic [8:0] tdo);
      capture();
      for (int i = 0; i < 9; i++) begin
         tdo[i] = jtdo1;
         shift_bit(tdi[i]);
      end
      update();
   endtask

   task automatic push(input logic [7:0] d);
      @(negedge clock);
      tx_data = d;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
   endtask

   task automatic consume();
      @(negedge clock);
      rx_ready = 1'b1;
      @(negedge clock);
      rx_ready = 1'b0;
   endtask

   task automatic check_ovf(input string name, input int exp);
`ifdef JTAG_RESPONDER_OVERFLOW_EN
      check(name, {24'd0, overflow_count}, exp[31:0]);
`endif
   endtask

   logic [8:0] tdo;
   logic [8:0] tdi_r;

   initial begin
      vecs[0] = '{1'b1, 8'hA5, 9'h000, 9'h14B, 1'b0, 8'h00, 8'd0, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 9'h079, 9'h000, 1'b1, 8'h3C, 8'd0, 1'b1};
      vecs[2] = '{1'b0, 8'h00, 9'h1FE, 9'h000, 1'b0, 8'h3C, 8'd0, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 9'h023, 9'h000, 1'b1, 8'h11, 8'd0, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 9'h045, 9'h000, 1'b1, 8'h22, 8'd1, 1'b1};
      vecs[5] = '{1'b1, 8'h5A, 9'h000, 9'h0B5, 1'b0, 8'h22, 8'd1, 1'b0};

      wait_clk(3);
      check("reset_jtdo1", {31'd0, jtdo1}, 32'd0);
      check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check_ovf("reset_ovf", 0);
      reset = 1'b0;
      wait_clk(4);

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].load) begin
            push(vecs[v].load_data);
            check($sformatf("vec%0d_tx_ready_full", v), {31'd0, tx_ready}, 32'd0);
         end
         scan(vecs[v].tdi, tdo);
         check($sformatf("vec%0d_tdo", v), {23'd0, tdo}, {23'd0, vecs[v].exp_tdo});
         check($sformatf("vec%0d_tx_ready", v), {31'd0, tx_ready}, 32'd1);
         check($sformatf("vec%0d_rx_valid", v), {31'd0, rx_valid}, {31'd0, vecs[v].exp_rx_valid});
         check($sformatf("vec%0d_rx_data", v), {24'd0, rx_data}, {24'd0, vecs[v].exp_rx_data});
         check_ovf($sformatf("vec%0d_ovf", v), int'(vecs[v].exp_ovf));
         if (vecs[v].consume) begin
            consume();
            check($sformatf("vec%0d_rx_consumed", v), {31'd0, rx_valid}, 32'd0);
         end
      end

      // Consumer idle-ready with no word pending clears the overwrite count.
      consume();
      check_ovf("ovf_clear", 0);

      // TAP reset mid-shift: FSM and shreg clear, held TX word survives.
      push(8'h5A);
      capture();
      for (int i = 0; i < 4; i++) shift_bit(1'b0);
      check("pre_jrstn_jtdo1", {31'd0, jtdo1}, 32'd1);
      push(8'h5A);
      jrstn = 1'b0;
      wait_clk(8);
      check("jrstn_jtdo1", {31'd0, jtdo1}, 32'd0);
      check("jrstn_hold_kept", {31'd0, tx_ready}, 32'd0);
      jrstn = 1'b1;
      jce1 = 1'b0;
      jshift = 1'b0;
      wait_clk(6);
      scan(9'h000, tdo);
      check("jrstn_rescan_tdo", {23'd0, tdo}, 32'h0B5);
      check("jrstn_rescan_tx_ready", {31'd0, tx_ready}, 32'd1);

      // Asynchronous reset mid-shift with a pending RX word and a held TX word.
      scan(9'h0EF, tdo);
      push(8'hC3);
      capture();
      shift_bit(1'b1);
      shift_bit(1'b1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("areset_jtdo1", {31'd0, jtdo1}, 32'd0);
      check("areset_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("areset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("areset_rx_data", {24'd0, rx_data}, 32'd0);
      check_ovf("areset_ovf", 0);
      jce1 = 1'b0;
      jshift = 1'b0;
      jtdi = 1'b0;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(4);
      scan(9'h0EF, tdo);
      check("post_reset_tdo", {23'd0, tdo}, 32'd0);
      check("post_reset_rx_valid", {31'd0, rx_valid}, 32'd1);
      check("post_reset_rx_data", {24'd0, rx_data}, 32'h77);

      // Random traffic against the model.
      m_hold_full = 1'b0;
      m_hold_data = 8'h00;
      m_rx_valid  = 1'b1;
      m_rx_data   = 8'h77;
      m_ovf       = 0;
      for (int it = 0; it < 40; it++) begin
         int op;
         op = int'($urandom_range(0, 3));
         if (op == 0) begin
            logic [7:0] d;
            d = 8'($urandom);
            push(d);
            if (!m_hold_full) begin
               m_hold_full = 1'b1;
               m_hold_data = d;
            end
         end else if (op == 1 || op == 3) begin
            logic [8:0] exp_tdo;
            tdi_r = 9'($urandom);
            exp_tdo = m_hold_full ? {m_hold_data, 1'b1} : 9'h000;
            m_hold_full = 1'b0;
            scan(tdi_r, tdo);
            if (tdi_r[0]) begin
               if (m_rx_valid && m_ovf < 255) m_ovf = m_ovf + 1;
               m_rx_valid = 1'b1;
               m_rx_data  = tdi_r[8:1];
            end
            check($sformatf("rnd%0d_tdo", it), {23'd0, tdo}, {23'd0, exp_tdo});
         end else begin
            consume();
            if (m_rx_valid) m_rx_valid = 1'b0;
            else m_ovf = 0;
         end
         check($sformatf("rnd%0d_tx_ready", it), {31'd0, tx_ready}, {31'd0, ~m_hold_full});
         check($sformatf("rnd%0d_rx_valid", it), {31'd0, rx_valid}, {31'd0, m_rx_valid});
         check($sformatf("rnd%0d_rx_data", it), {24'd0, rx_data}, {24'd0, m_rx_data});
         check_ovf($sformatf("rnd%0d_ovf", it), m_ovf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jtag_user_responder.md
Name: jtag_user_responder

Overview:
- Target-side end of the ECP5 JTAGG user-register (ER1) channel; the host-to-target direction is the JTDI probe path.
- Drives JTDO1 back to the host.
- Presents a parallel TX word (fabric→host) and receives an RX word (host→fabric) through valid/ready handshakes in the system clock domain.
- All JTAGG strobes are oversampled by the system clock, so no logic runs on JTCK.

Parameters:
- WIDTH, 8, payload bits per transfer. The scan chain is WIDTH+1 bits long: payload plus one flag bit at the LSB.
- SYNC_STAGES, 2, synchronizer flops on every JTAGG input (minimum 2).

Ports:
- clock  input  1  system clock; must be ≥ 8× JTCK frequency
- reset  input  1  asynchronous, active-high
- jtck  input  1  JTCK from JTAGG
- jtdi  input  1  JTDI from JTAGG
- jshift  input  1  JSHIFT from JTAGG
- jupdate  input  1  JUPDATE from JTAGG
- jce1  input  1  JCE1 from JTAGG (ER1 selected)
- jrstn  input  1  JRSTN from JTAGG, active-low TAP reset
- jtdo1  output  1  to JTAGG JTDO1
- tx_data  input  WIDTH  word to send to host
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  holding register empty
- rx_data  output  WIDTH  word received from host
- rx_valid  output  1  rx_data valid
- rx_ready  input  1  consumer accepts rx_data

Behaviour:
- Reset: asynchronous and active-high, applied to all flops.
- Reset values:
  - jtdo1=0
  - tx_ready=1
  - rx_data=0
  - rx_valid=0
  - shift register = 0
  - hold_full=0
  - FSM = IDLE
- Synchronizing and edge detection: all JTAGG inputs pass through SYNC_STAGES flops. A jtck rise or jupdate rise is detected one cycle after the synchronized level changes. All actions below happen in the cycle the edge is detected, using the synchronized jshift, jce1 and jtdi from that same cycle.
- TX holding register:
  - It loads when tx_valid & tx_ready, which sets hold_full. tx_ready = ~hold_full.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on jtck rise with jce1=1, jshift=0 (capture). The action is shreg <= {hold_data, hold_full}, then hold_full clears.
    - If the holding register is empty, shreg <= 0, so the flag bit is 0 and tells the host "no data".
  - SHIFT, on jtck rise with jce1=1, jshift=1: shreg <= {jtdi, shreg[WIDTH:1]}.
  - SHIFT → DONE on jupdate rise.
    - If shreg[0]=1 (host flag = write), then rx_data <= shreg[WIDTH:1] and rx_valid <= 1.
    - If shreg[0]=0, rx_data and rx_valid are unchanged.
  - DONE → IDLE on the next cycle.
  - jupdate rise while in IDLE is ignored.
- jtdo1 is registered and equals shreg[0]. It updates the cycle after each capture or shift, which is within SYNC_STAGES+2 clocks of the JTCK rise and well before the following rise.
- RX handshake: rx_valid holds until rx_valid & rx_ready, then clears.
  - A new update while rx_valid=1 overwrites rx_data and keeps rx_valid=1. The old word is lost (see overflow).
- Same-cycle tx load and capture: the capture uses the old hold state. If hold was empty, the new word stays held for the next scan.
- Synchronized jrstn=0 forces the FSM to IDLE and shreg to 0 in any state, e.g. a TAP reset mid-shift.
  - hold and rx registers are unaffected, so a held TX word is not lost.
- A capture or shift with jce1=0 (another user register selected) is ignored.

Optional Feature:
- Macro: JTAG_RESPONDER_OVERFLOW_EN.
- Defined:
  - Adds output port overflow_count [7:0], reset to 0.
  - It increments, saturating at 255, on every update that overwrites an unconsumed rx word.
  - It clears when rx_ready=1 and rx_valid=0 for one cycle while the synchronized jce1=0.
- Undefined: the port, counter and logic are absent. Overwrite behaviour is identical.

Test Plan:
- Load tx_data=0xA5, then scan 9 bits with TDI=0 → TDO sequence LSB-first 1,1,0,1,0,0,1,0,1 (flag then 0xA5). tx_ready returns to 1 after the capture.
- Scan with empty hold, TDI = flag 1 + payload 0x3C → TDO all 0s. After jupdate, rx_data=0x3C and rx_valid=1, held until rx_ready pulses.
- Scan with TDI flag=0, payload 0xFF → rx_valid stays 0 and rx_data unchanged.
- Two writes (0x11, then 0x22) with rx_ready=0 → rx_data=0x22, rx_valid=1, and overflow_count=1 when the macro is enabled.
- Pull jrstn low after 4 shift bits, then do a fresh full scan of held 0x5A → FSM back to IDLE and jtdo1=0. The full scan returns flag 1 + 0x5A intact.
- Assert reset mid-shift → all outputs at reset values within the same cycle (asynchronous). The next scan behaves as from power-up.
